// File: rtl/mem_arbiter_if.sv
// Bundles the core-array request lines and the shared-SRAM port of the memory arbiter.
// The arbiter connects through the slave modport; the core/SRAM side uses master.
interface mem_arbiter_if #(
  parameter int CORE_COUNT   = 4,
  parameter int REG_SIZE     = 8,
  parameter int CORE_ID_SIZE = 2
);
  localparam int ADDR_SIZE = CORE_ID_SIZE + REG_SIZE;

  logic [2*CORE_COUNT-1:0]         enable_M_bus;
  logic [ADDR_SIZE*CORE_COUNT-1:0] addr_M_bus;
  logic [REG_SIZE*CORE_COUNT-1:0]  wr_data_M_bus;
  logic [CORE_COUNT-1:0]           ready_M_bus;
  logic [REG_SIZE-1:0]             rd_data_M;
  logic [1:0]                      mem_enable;
  logic [ADDR_SIZE-1:0]            mem_addr;
  logic [REG_SIZE-1:0]             mem_wr_data;
  logic [REG_SIZE-1:0]             mem_rd_data;
  logic                            arb_busy;

  modport master (
    output enable_M_bus, addr_M_bus, wr_data_M_bus, mem_rd_data,
    input  ready_M_bus, rd_data_M, mem_enable, mem_addr, mem_wr_data, arb_busy
  );

  modport slave (
    input  enable_M_bus, addr_M_bus, wr_data_M_bus, mem_rd_data,
    output ready_M_bus, rd_data_M, mem_enable, mem_addr, mem_wr_data, arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between CORE_COUNT cores.
// Each grant runs IDLE -> ISSUE -> DONE; DONE may chain straight into the next ISSUE.
module mem_arbiter #(
  parameter int CORE_COUNT   = 4,
  parameter int REG_SIZE     = 8,
  parameter int CORE_ID_SIZE = 2
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int ADDR_SIZE = CORE_ID_SIZE + REG_SIZE;
  localparam int IDX_W     = $clog2(CORE_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [1:0]            en_s    [CORE_COUNT];
  logic [ADDR_SIZE-1:0]  addr_s  [CORE_COUNT];
  logic [REG_SIZE-1:0]   wdata_s [CORE_COUNT];
  logic [CORE_COUNT-1:0] req_s;
  logic [CORE_COUNT-1:0] mask_s;
  logic                  win_valid_s;
  logic [IDX_W-1:0]      win_idx_s;

  logic [1:0]            mem_enable_s;
  logic [ADDR_SIZE-1:0]  mem_addr_s;
  logic [REG_SIZE-1:0]   mem_wr_data_s;
  logic [CORE_COUNT-1:0] ready_s;
  logic [REG_SIZE-1:0]   rd_data_s;

  // First requester found scanning upward from ptr with wrap; MSB flags a valid winner.
  function automatic logic [IDX_W:0] rr_pick(input logic [CORE_COUNT-1:0] req,
                                             input logic [IDX_W-1:0]      ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % CORE_COUNT);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(CORE_COUNT - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Split the flat per-core buses; only 01/10 count as requests.
  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      en_s[i]    = bus.enable_M_bus[2*i +: 2];
      addr_s[i]  = bus.addr_M_bus[ADDR_SIZE*i +: ADDR_SIZE];
      wdata_s[i] = bus.wr_data_M_bus[REG_SIZE*i +: REG_SIZE];
      req_s[i]   = en_s[i][1] ^ en_s[i][0];
    end
  end

  // The grantee's request is still visible in DONE and must not win again.
  always_comb begin
    mask_s = '0;
    if (state_q == DONE) begin
      mask_s[grant_idx_q] = 1'b1;
    end else begin
      mask_s = '0;
    end
    {win_valid_s, win_idx_s} = rr_pick(req_s & ~mask_s, rr_ptr_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE, DONE: begin
        if (win_valid_s) begin
          state_d     = ISSUE;
          grant_idx_d = win_idx_s;
          rr_ptr_d    = rr_next(win_idx_s);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; reset suppresses the SRAM enable and the ready pulse in the same cycle.
  always_comb begin
    mem_enable_s  = 2'b00;
    mem_addr_s    = '0;
    mem_wr_data_s = '0;
    ready_s       = '0;
    rd_data_s     = '0;
    case (state_q)
      ISSUE: begin
        mem_enable_s  = reset ? 2'b00 : en_s[grant_idx_q];
        mem_addr_s    = addr_s[grant_idx_q];
        mem_wr_data_s = wdata_s[grant_idx_q];
      end
      DONE: begin
        ready_s[grant_idx_q] = ~reset;
        rd_data_s            = bus.mem_rd_data;
      end
      default: begin
        mem_enable_s = 2'b00;
      end
    endcase
  end

  assign bus.mem_enable  = mem_enable_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wr_data = mem_wr_data_s;
  assign bus.ready_M_bus = ready_s;
  assign bus.rd_data_M   = rd_data_s;
  assign bus.arb_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// core traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int RS = 8;
  localparam int AS = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter_if #(.CORE_COUNT(N), .REG_SIZE(RS), .CORE_ID_SIZE(2)) ifc ();

  mem_arbiter #(.CORE_COUNT(N), .REG_SIZE(RS), .CORE_ID_SIZE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  logic [2*N-1:0]  en_v   = '0;
  logic [AS*N-1:0] addr_v = '0;
  logic [RS*N-1:0] wd_v   = '0;
  assign ifc.enable_M_bus  = en_v;
  assign ifc.addr_M_bus    = addr_v;
  assign ifc.wr_data_M_bus = wd_v;

  // SRAM environment: unwritten locations read as a fixed address pattern.
  bit [7:0] sram    [0:1023];
  bit       sram_wr [0:1023];
  bit [7:0] sram_rd = 8'h00;
  assign ifc.mem_rd_data = sram_rd;

  function automatic logic [7:0] init_val(input logic [9:0] a);
    return a[7:0] ^ 8'h99;
  endfunction

  function automatic logic [7:0] sram_peek(input logic [9:0] a);
    return sram_wr[a] ? sram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (ifc.mem_enable == 2'b01) begin
      sram_rd <= sram_peek(ifc.mem_addr);
    end else if (ifc.mem_enable == 2'b10) begin
      sram[ifc.mem_addr]    <= ifc.mem_wr_data;
      sram_wr[ifc.mem_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] core_en(input int c);
    return ifc.enable_M_bus[2*c +: 2];
  endfunction
  function automatic logic [9:0] core_addr(input int c);
    return ifc.addr_M_bus[AS*c +: AS];
  endfunction
  function automatic logic [7:0] core_wd(input int c);
    return ifc.wr_data_M_bus[RS*c +: RS];
  endfunction
  function automatic bit is_req(input int c);
    return (core_en(c) == 2'b01) || (core_en(c) == 2'b10);
  endfunction

  // Reference model: one transaction at a time, aged 1 (SRAM access) then 2 (completion).
  int       m_cur = -1;
  int       m_age = 0;
  int       m_ptr = 0;
  bit [7:0] m_mem [0:1023];
  bit       m_wr  [0:1023];
  bit [7:0] m_last_rd = 8'h00;
  logic [N-1:0] seen_ready = '0;

  always @(negedge clk) begin : model
    logic [1:0]   e_en;
    logic [9:0]   e_addr;
    logic [7:0]   e_wd;
    logic [N-1:0] e_rdy;
    logic [7:0]   e_rd;
    logic [9:0]   a;
    int           pick;
    int           c;
    e_en = 2'b00; e_addr = '0; e_wd = '0; e_rdy = '0; e_rd = '0;
    if (m_cur >= 0 && m_age == 1) begin
      e_en   = reset ? 2'b00 : core_en(m_cur);
      e_addr = core_addr(m_cur);
      e_wd   = core_wd(m_cur);
    end
    if (m_cur >= 0 && m_age == 2) begin
      e_rdy[m_cur] = !reset;
      e_rd         = m_last_rd;
    end
    check("model_mem_enable",  32'(ifc.mem_enable),  32'(e_en));
    check("model_mem_addr",    32'(ifc.mem_addr),    32'(e_addr));
    check("model_mem_wr_data", 32'(ifc.mem_wr_data), 32'(e_wd));
    check("model_ready",       32'(ifc.ready_M_bus), 32'(e_rdy));
    check("model_rd_data",     32'(ifc.rd_data_M),   32'(e_rd));
    check("model_busy",        32'(ifc.arb_busy),    32'(m_cur >= 0));
    seen_ready = e_rdy;
    if (reset) begin
      m_cur = -1; m_age = 0; m_ptr = 0;
    end else if (m_age == 1) begin
      a = core_addr(m_cur);
      if (core_en(m_cur) == 2'b01) begin
        m_last_rd = m_wr[a] ? m_mem[a] : init_val(a);
      end else if (core_en(m_cur) == 2'b10) begin
        m_mem[a] = core_wd(m_cur);
        m_wr[a]  = 1'b1;
      end
      m_age = 2;
    end else begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (pick < 0 && is_req(c) && !(m_age == 2 && c == m_cur)) pick = c;
      end
      if (pick >= 0) begin
        m_cur = pick; m_age = 1; m_ptr = (pick + 1) % N;
      end else begin
        m_cur = -1; m_age = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_core(input int c, input logic [1:0] en, input logic [9:0] a, input logic [7:0] d);
    en_v[2*c +: 2]    = en;
    addr_v[AS*c +: AS] = a;
    wd_v[RS*c +: RS]   = d;
  endtask

  logic [9:0] all_addr [N];
  logic [7:0] all_rd   [N];
  int pend;

  initial begin
    all_addr[0] = 10'h040; all_addr[1] = 10'h141; all_addr[2] = 10'h242; all_addr[3] = 10'h343;
    all_rd[0] = 8'hD9; all_rd[1] = 8'hD8; all_rd[2] = 8'hDB; all_rd[3] = 8'hDA;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    neg();
    check("reset_busy", 32'(ifc.arb_busy), 32'd0);
    check("reset_ready", 32'(ifc.ready_M_bus), 32'd0);
    check("reset_mem_enable", 32'(ifc.mem_enable), 32'd0);
    tick();
    reset = 1'b0;

    // All four cores request from reset: grants 0,1,2,3,0,1,2,3
    for (int i = 0; i < N; i++) set_core(i, 2'b01, all_addr[i], 8'h00);
    neg();
    check("all4_idle_first", 32'(ifc.arb_busy), 32'd0);
    pend = -1;
    for (int g = 0; g < 8; g++) begin
      tick();
      if (pend >= 0) set_core(pend, 2'b00, 10'd0, 8'd0);
      neg();
      check("all4_issue_en", 32'(ifc.mem_enable), 32'd1);
      check("all4_issue_addr", 32'(ifc.mem_addr), 32'(all_addr[g % N]));
      check("all4_issue_busy", 32'(ifc.arb_busy), 32'd1);
      tick();
      neg();
      check("all4_ready", 32'(ifc.ready_M_bus), 32'(4'b0001 << (g % N)));
      check("all4_rd_data", 32'(ifc.rd_data_M), 32'(all_rd[g % N]));
      check("all4_done_busy", 32'(ifc.arb_busy), 32'd1);
      pend = (g >= 4) ? (g % N) : -1;
    end
    tick();
    set_core(pend, 2'b00, 10'd0, 8'd0);
    neg();
    check("all4_back_idle", 32'(ifc.arb_busy), 32'd0);

    // Single LD from core 2
    tick();
    set_core(2, 2'b01, 10'h2A5, 8'h00);
    neg();
    tick(); neg();
    check("ld_mem_enable", 32'(ifc.mem_enable), 32'd1);
    check("ld_mem_addr", 32'(ifc.mem_addr), 32'h2A5);
    tick(); neg();
    check("ld_ready", 32'(ifc.ready_M_bus), 32'b0100);
    check("ld_rd_data", 32'(ifc.rd_data_M), 32'h3C);
    tick();
    set_core(2, 2'b00, 10'd0, 8'd0);
    neg();
    check("ld_back_idle", 32'(ifc.arb_busy), 32'd0);
    check("ld_no_ready", 32'(ifc.ready_M_bus), 32'd0);

    // Cores 3 and 0 with pointer at 3: core 3 first, core 0 chained from DONE
    tick();
    set_core(3, 2'b01, 10'h305, 8'h00);
    set_core(0, 2'b01, 10'h0F0, 8'h00);
    neg();
    tick(); neg();
    check("wrap_first_addr", 32'(ifc.mem_addr), 32'h305);
    tick(); neg();
    check("wrap_first_ready", 32'(ifc.ready_M_bus), 32'b1000);
    check("wrap_first_rd", 32'(ifc.rd_data_M), 32'h9C);
    tick();
    set_core(3, 2'b00, 10'd0, 8'd0);
    neg();
    check("wrap_chain_en", 32'(ifc.mem_enable), 32'd1);
    check("wrap_chain_addr", 32'(ifc.mem_addr), 32'h0F0);
    tick(); neg();
    check("wrap_second_ready", 32'(ifc.ready_M_bus), 32'b0001);
    check("wrap_second_rd", 32'(ifc.rd_data_M), 32'h69);
    tick();
    set_core(0, 2'b00, 10'd0, 8'd0);
    neg();
    check("wrap_back_idle", 32'(ifc.arb_busy), 32'd0);

    // Single ST from core 1
    tick();
    set_core(1, 2'b10, 10'h10F, 8'h77);
    neg();
    tick(); neg();
    check("st_mem_enable", 32'(ifc.mem_enable), 32'd2);
    check("st_mem_wr_data", 32'(ifc.mem_wr_data), 32'h77);
    check("st_mem_addr", 32'(ifc.mem_addr), 32'h10F);
    tick(); neg();
    check("st_ready", 32'(ifc.ready_M_bus), 32'b0010);
    tick();
    set_core(1, 2'b00, 10'd0, 8'd0);
    neg();
    check("st_sram_written", 32'(sram_peek(10'h10F)), 32'h77);
    check("st_back_idle", 32'(ifc.arb_busy), 32'd0);

    // Encoding 11 is never granted
    tick();
    set_core(0, 2'b11, 10'h0AA, 8'h12);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("en11_mem_enable", 32'(ifc.mem_enable), 32'd0);
      check("en11_busy", 32'(ifc.arb_busy), 32'd0);
      tick();
    end
    set_core(0, 2'b00, 10'd0, 8'd0);

    // Reset during ISSUE of a store
    set_core(2, 2'b10, 10'h3C1, 8'h55);
    neg();
    tick();
    reset = 1'b1;
    neg();
    check("rst_issue_mem_enable", 32'(ifc.mem_enable), 32'd0);
    check("rst_issue_busy", 32'(ifc.arb_busy), 32'd1);
    check("rst_issue_ready", 32'(ifc.ready_M_bus), 32'd0);
    tick();
    reset = 1'b0;
    set_core(2, 2'b00, 10'd0, 8'd0);
    set_core(1, 2'b01, 10'h111, 8'h00);
    set_core(3, 2'b01, 10'h333, 8'h00);
    neg();
    check("rst_after_idle", 32'(ifc.arb_busy), 32'd0);
    check("rst_sram_unchanged", 32'(sram_peek(10'h3C1)), 32'h58);
    tick(); neg();
    check("rst_ptr0_addr", 32'(ifc.mem_addr), 32'h111);
    tick(); neg();
    check("rst_ptr0_ready", 32'(ifc.ready_M_bus), 32'b0010);
    check("rst_ptr0_rd", 32'(ifc.rd_data_M), 32'h88);
    tick();
    set_core(1, 2'b00, 10'd0, 8'd0);
    neg();
    check("rst_next_addr", 32'(ifc.mem_addr), 32'h333);
    tick(); neg();
    check("rst_next_ready", 32'(ifc.ready_M_bus), 32'b1000);
    check("rst_next_rd", 32'(ifc.rd_data_M), 32'hAA);
    tick();
    set_core(3, 2'b00, 10'd0, 8'd0);
    neg();
    check("rst_final_idle", 32'(ifc.arb_busy), 32'd0);

    // Random traffic: cores hold requests until their ready pulse, occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      reset = ($urandom_range(0, 249) == 0);
      for (int c = 0; c < N; c++) begin
        if (seen_ready[c] || !is_req(c)) begin
          if ($urandom_range(0, 2) == 0) begin
            set_core(c, 2'($urandom_range(1, 2)),
                     {2'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7))},
                     8'($urandom));
          end else begin
            set_core(c, ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, 10'd0, 8'd0);
          end
        end
      end
    end
    tick();
    reset = 1'b0;
    en_v  = '0;
    repeat (4) tick();
    neg();
    check("end_idle", 32'(ifc.arb_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
